// File: rtl/bram_test_sequencer.sv
// bram_test_sequencer: issues LFSR seeds to a BRAM test engine and tallies pass/fail status per campaign.
// Optional watchdog enabled with `define BRAM_TEST_SEQ_TIMEOUT_EN.
module bram_test_sequencer #(
    parameter int          NUM_RUNS       = 16,
    parameter logic [31:0] SEED_INIT      = 32'h0000_0001,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        seed_tvalid,
    input  logic        seed_tready,
    output logic [31:0] seed_tdata,
    input  logic        status_tvalid,
    output logic        status_tready,
    input  logic [31:0] status_tdata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic [31:0] first_fail_seed
);
    typedef enum logic [1:0] {IDLE, SEND_SEED, WAIT_STATUS, HALT} state_t;
    state_t state, state_next;
    logic [31:0] seed, seed_shift;
    logic [15:0] run_cnt;
    logic        accept, launch, last_run, wd_fire, seed_hs;
    logic        unused_status;
    assign unused_status = ^status_tdata[31:2];
    assign seed_tvalid   = state == SEND_SEED;
    assign seed_tdata    = seed;
    assign seed_hs       = seed_tvalid && seed_tready;
    assign status_tready = state == WAIT_STATUS && status_tvalid && status_tdata[1];
    assign accept        = status_tvalid && status_tready;
    assign busy          = state == SEND_SEED || state == WAIT_STATUS;
    assign launch        = (state == IDLE || state == HALT) && start;
    assign last_run      = {1'b0, run_cnt} + 17'd1 == 17'(NUM_RUNS);
    assign seed_shift    = {seed[30:0], seed[31] ^ seed[21] ^ seed[1] ^ seed[0]};
`ifdef BRAM_TEST_SEQ_TIMEOUT_EN
    logic [31:0] wd_cnt;
    assign wd_fire = state == WAIT_STATUS && !accept && wd_cnt == 32'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!reset || seed_hs)
            wd_cnt <= '0;
        else if (state == WAIT_STATUS && !accept)
            wd_cnt <= wd_cnt + 32'd1;
        if (!reset || launch)
            timeout <= 1'b0;
        else if (wd_fire)
            timeout <= 1'b1;
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif
    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_next;
    always_comb begin
        state_next = state;
        case (state)
            IDLE, HALT:  state_next = start ? SEND_SEED : state;
            SEND_SEED:   state_next = seed_hs ? WAIT_STATUS : state;
            WAIT_STATUS: state_next = accept ? (last_run ? IDLE : SEND_SEED) : (wd_fire ? HALT : state);
            default:     state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset || launch) begin
            seed            <= SEED_INIT;
            run_cnt         <= '0;
            pass_count      <= '0;
            fail_count      <= '0;
            first_fail_seed <= '0;
            done            <= 1'b0;
        end else if (accept) begin
            if (status_tdata[0])
                pass_count <= pass_count + {15'd0, pass_count != 16'hFFFF};
            else
                fail_count <= fail_count + {15'd0, fail_count != 16'hFFFF};
            if (!status_tdata[0] && fail_count == 16'd0)
                first_fail_seed <= seed;
            // all-zero seed would lock the LFSR, so it is replaced with 1
            seed    <= seed_shift == 32'd0 ? 32'd1 : seed_shift;
            run_cnt <= run_cnt + 16'd1;
            done    <= done | last_run;
        end else if (wd_fire) begin
            fail_count <= fail_count + {15'd0, fail_count != 16'hFFFF};
        end
    end
endmodule

// File: tb/tb_bram_test_sequencer.sv
// tb_bram_test_sequencer: directed checks of seed issue, status counting, backpressure, reset and watchdog.
module tb_bram_test_sequencer;
    localparam int NR = 4;
    localparam int TO = 16;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, seed_tready = 1'b0, status_tvalid = 1'b0;
    logic [31:0] status_tdata = '0;
    logic        seed_tvalid, status_tready, busy, done, timeout;
    logic [31:0] seed_tdata, first_fail_seed;
    logic [15:0] pass_count, fail_count;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] seeds [NR] = '{32'h1, 32'h3, 32'h6, 32'hD};

    bram_test_sequencer #(.NUM_RUNS(NR), .SEED_INIT(32'h1), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .seed_tvalid(seed_tvalid), .seed_tready(seed_tready), .seed_tdata(seed_tdata),
        .status_tvalid(status_tvalid), .status_tready(status_tready), .status_tdata(status_tdata),
        .busy(busy), .done(done), .timeout(timeout),
        .pass_count(pass_count), .fail_count(fail_count), .first_fail_seed(first_fail_seed)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic do_seed(input logic [31:0] exp);
        chk("seed_tvalid", 32'(seed_tvalid), 32'd1);
        chk("seed_tdata", seed_tdata, exp);
        chk("busy_send", 32'(busy), 32'd1);
        seed_tready = 1'b1;
        tick;
        seed_tready = 1'b0;
        chk("seed_tvalid_after_hs", 32'(seed_tvalid), 32'd0);
    endtask

    task automatic do_status(input logic pass);
        status_tvalid = 1'b1;
        status_tdata  = {30'h0, 1'b1, pass};
        #1;
        chk("status_tready_accept", 32'(status_tready), 32'd1);
        tick;
        status_tvalid = 1'b0;
        status_tdata  = '0;
    endtask

    task automatic check_end(input logic [31:0] p, input logic [31:0] f, input logic [31:0] ffs);
        chk("done_end", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("pass_count", 32'(pass_count), p);
        chk("fail_count", 32'(fail_count), f);
        chk("first_fail_seed", first_fail_seed, ffs);
        chk("timeout_end", 32'(timeout), 32'd0);
    endtask

    task automatic campaign(input int fail_idx, input logic [31:0] p, input logic [31:0] f, input logic [31:0] ffs);
        pulse_start;
        chk("done_cleared", 32'(done), 32'd0);
        for (int i = 0; i < NR; i++) begin
            do_seed(seeds[i]);
            do_status(i != fail_idx);
        end
        check_end(p, f, ffs);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_seed_tvalid", 32'(seed_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass_count), 32'd0);
        chk("rst_ffs", first_fail_seed, 32'd0);
        reset = 1'b1;
        tick;
        campaign(-1, 32'd4, 32'd0, 32'd0);
        campaign(1, 32'd3, 32'd1, 32'h3);
        // seed backpressure and status words without the done bit
        pulse_start;
        for (int i = 0; i < 10; i++) begin
            chk("bp_tvalid", 32'(seed_tvalid), 32'd1);
            chk("bp_tdata", seed_tdata, 32'h1);
            tick;
        end
        do_seed(32'h1);
        status_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            status_tdata = i[0] ? 32'hFFFF_FFFD : 32'h1;
            #1;
            chk("nodone_tready", 32'(status_tready), 32'd0);
            tick;
            chk("nodone_busy", 32'(busy), 32'd1);
        end
        do_status(1'b1);
        for (int i = 1; i < NR; i++) begin
            do_seed(seeds[i]);
            do_status(1'b1);
        end
        check_end(32'd4, 32'd0, 32'd0);
        // reset in WAIT_STATUS of run 3, with start held during reset
        pulse_start;
        do_seed(32'h1);
        do_status(1'b0);
        do_seed(32'h3);
        do_status(1'b1);
        do_seed(32'h6);
        chk("pre_rst_fail", 32'(fail_count), 32'd1);
        chk("pre_rst_ffs", first_fail_seed, 32'h1);
        status_tvalid = 1'b1;
        status_tdata  = 32'h3;
        reset = 1'b0;
        start = 1'b1;
        tick;
        chk("mid_rst_tvalid", 32'(seed_tvalid), 32'd0);
        chk("mid_rst_tready", 32'(status_tready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pass", 32'(pass_count), 32'd0);
        chk("mid_rst_fail", 32'(fail_count), 32'd0);
        chk("mid_rst_ffs", first_fail_seed, 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        status_tvalid = 1'b0;
        status_tdata  = '0;
        reset = 1'b1;
        start = 1'b0;
        tick;
        chk("post_rst_busy", 32'(busy), 32'd0);
        campaign(-1, 32'd4, 32'd0, 32'd0);
`ifdef BRAM_TEST_SEQ_TIMEOUT_EN
        pulse_start;
        do_seed(32'h1);
        status_tvalid = 1'b1;
        status_tdata  = 32'h1;
        for (int i = 0; i < TO - 1; i++) tick;
        chk("wd_not_yet", 32'(timeout), 32'd0);
        tick;
        chk("wd_timeout", 32'(timeout), 32'd1);
        chk("wd_fail", 32'(fail_count), 32'd1);
        chk("wd_halt_busy", 32'(busy), 32'd0);
        status_tvalid = 1'b0;
        pulse_start;
        chk("wd_restart_timeout", 32'(timeout), 32'd0);
        chk("wd_restart_fail", 32'(fail_count), 32'd0);
        chk("wd_restart_tdata", seed_tdata, 32'h1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
